// File: rtl/lcd_char_interface_if.sv
// Host write port and LCD pin bundle for the 2x16 character LCD driver.
// The host drives the W/WADD/Din write strobe; the driver owns the panel pins.
interface lcd_char_interface_if;
    logic       W;
    logic [5:0] WADD;
    logic [7:0] Din;
    logic [3:0] dataout;
    logic [2:0] control;

    modport master (output W, WADD, Din, input dataout, control);
    modport slave  (input W, WADD, Din, output dataout, control);
endinterface

// File: rtl/lcd_char_interface.sv
// HD44780 2x16 driver in 4-bit write-only mode: power-up init, configuration,
// then an endless refresh of both lines from a 32-byte host-written buffer.
module lcd_char_interface #(
    parameter int PWRUP_CYC = 750000,
    parameter int INIT_GAP  = 205000,
    parameter int E_CYC     = 12,
    parameter int NIB_GAP   = 50,
    parameter int BYTE_GAP  = 2000,
    parameter int CLR_GAP   = 82000
) (
    input  logic                  clk,
    input  logic                  reset,
    lcd_char_interface_if.slave   lcd_if
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max2(max2(max2(PWRUP_CYC, INIT_GAP), BYTE_GAP + CLR_GAP),
                                  max2(E_CYC, NIB_GAP));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PWRUP_LAST    = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] INIT_LAST     = CNT_W'(INIT_GAP - 1);
    localparam logic [CNT_W-1:0] E_LAST        = CNT_W'(E_CYC - 1);
    localparam logic [CNT_W-1:0] NIB_LAST      = CNT_W'(NIB_GAP - 1);
    localparam logic [CNT_W-1:0] BYTE_LAST     = CNT_W'(BYTE_GAP - 1);
    localparam logic [CNT_W-1:0] BYTE_CLR_LAST = CNT_W'(BYTE_GAP + CLR_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO      = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0,
        INIT     = 3'd1,
        CFG      = 3'd2,
        ADDR1    = 3'd3,
        LINE1    = 3'd4,
        ADDR2    = 3'd5,
        LINE2    = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        PH_SETUP = 2'd0,
        PH_E     = 2'd1,
        PH_HOLD  = 2'd2,
        PH_GAP   = 2'd3
    } phase_e;

    state_e           state_q, state_d;
    phase_e           phase_q, phase_d;
    logic [3:0]       step_q, step_d;
    logic             half_q, half_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic [3:0]       dout_q, dout_d;
    logic             rs_q, rs_d;
    logic             e_q, e_d;
    logic [7:0]       char_q [32];

    logic [CNT_W-1:0] gap_last_s;
    logic             load_s;
    logic             advance_s;
    logic [7:0]       src_s;

    // Character buffer: reset fills with spaces, host writes land one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                char_q[i] <= 8'h20;
            end
        end else if (lcd_if.W && !lcd_if.WADD[5]) begin
            char_q[lcd_if.WADD[4:0]] <= lcd_if.Din;
        end else begin
            char_q <= char_q;
        end
    end

    // Sequencer and registered panel outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PWR_WAIT;
            phase_q <= PH_SETUP;
            step_q  <= 4'd0;
            half_q  <= 1'b0;
            cnt_q   <= CNT_ZERO;
            byte_q  <= 8'h00;
            dout_q  <= 4'h0;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            step_q  <= step_d;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            dout_q  <= dout_d;
            rs_q    <= rs_d;
            e_q     <= e_d;
        end
    end

    // Gap after the current nibble; init nibbles are standalone, the clear command waits longer.
    always_comb begin
        gap_last_s = BYTE_LAST;
        if (state_q == INIT) begin
            gap_last_s = (step_q == 4'd3) ? BYTE_LAST : INIT_LAST;
        end else if (!half_q) begin
            gap_last_s = NIB_LAST;
        end else if ((state_q == CFG) && (step_q == 4'd3)) begin
            gap_last_s = BYTE_CLR_LAST;
        end else begin
            gap_last_s = BYTE_LAST;
        end
    end

    // Next-state logic: phase engine per nibble, step/state advance per byte.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        step_d    = step_q;
        half_d    = half_q;
        cnt_d     = cnt_q;
        byte_d    = byte_q;
        dout_d    = dout_q;
        rs_d      = rs_q;
        load_s    = 1'b0;
        advance_s = 1'b0;
        src_s     = 8'h00;

        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == PWRUP_LAST) begin
                    state_d = INIT;
                    phase_d = PH_SETUP;
                    step_d  = 4'd0;
                    half_d  = 1'b0;
                    cnt_d   = CNT_ZERO;
                    load_s  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                case (phase_q)
                    PH_SETUP: begin
                        phase_d = PH_E;
                        cnt_d   = CNT_ZERO;
                    end
                    PH_E: begin
                        if (cnt_q == E_LAST) begin
                            phase_d = PH_HOLD;
                            cnt_d   = CNT_ZERO;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    PH_HOLD: begin
                        phase_d = PH_GAP;
                        cnt_d   = CNT_ZERO;
                    end
                    PH_GAP: begin
                        if (cnt_q == gap_last_s) begin
                            cnt_d   = CNT_ZERO;
                            phase_d = PH_SETUP;
                            load_s  = 1'b1;
                            if ((state_q != INIT) && !half_q) begin
                                half_d = 1'b1;
                            end else begin
                                half_d    = 1'b0;
                                advance_s = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        phase_d = PH_SETUP;
                        cnt_d   = CNT_ZERO;
                    end
                endcase
            end
        endcase

        if (advance_s) begin
            case (state_q)
                INIT: begin
                    if (step_q == 4'd3) begin
                        state_d = CFG;
                        step_d  = 4'd0;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
                CFG: begin
                    if (step_q == 4'd3) begin
                        state_d = ADDR1;
                        step_d  = 4'd0;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
                ADDR1: begin
                    state_d = LINE1;
                    step_d  = 4'd0;
                end
                LINE1: begin
                    if (step_q == 4'd15) begin
                        state_d = ADDR2;
                        step_d  = 4'd0;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
                ADDR2: begin
                    state_d = LINE2;
                    step_d  = 4'd0;
                end
                LINE2: begin
                    if (step_q == 4'd15) begin
                        state_d = ADDR1;
                        step_d  = 4'd0;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
                default: begin
                    state_d = PWR_WAIT;
                    step_d  = 4'd0;
                end
            endcase
        end else begin
            step_d = step_d;
        end

        case (state_d)
            INIT:    src_s = (step_d == 4'd3) ? 8'h20 : 8'h30;
            CFG: begin
                case (step_d)
                    4'd0:    src_s = 8'h28;
                    4'd1:    src_s = 8'h06;
                    4'd2:    src_s = 8'h0C;
                    default: src_s = 8'h01;
                endcase
            end
            ADDR1:   src_s = 8'h80;
            LINE1:   src_s = char_q[{1'b0, step_d}];
            ADDR2:   src_s = 8'hC0;
            LINE2:   src_s = char_q[{1'b1, step_d}];
            default: src_s = 8'h00;
        endcase

        // The character is captured once per byte so both nibbles come from the same value.
        if (load_s) begin
            rs_d = (state_d == LINE1) || (state_d == LINE2);
            if (!half_d) begin
                byte_d = src_s;
                dout_d = src_s[7:4];
            end else begin
                dout_d = byte_q[3:0];
            end
        end else begin
            rs_d = rs_q;
        end

        e_d = (state_d != PWR_WAIT) && (phase_d == PH_E);
    end

    assign lcd_if.dataout = dout_q;
    assign lcd_if.control = {e_q, rs_q, 1'b0};

endmodule

// File: tb/tb_lcd_char_interface.sv
// Scoreboard bench for lcd_char_interface: expected {RS,nibble} pairs are queued
// ahead of time and compared on every rising edge of LCD_E.
module tb_lcd_char_interface;

    localparam int E_CYC = 2;

    logic clk = 1'b0;
    logic reset;

    lcd_char_interface_if bus_if ();

    lcd_char_interface #(
        .PWRUP_CYC (20),
        .INIT_GAP  (10),
        .E_CYC     (E_CYC),
        .NIB_GAP   (3),
        .BYTE_GAP  (5),
        .CLR_GAP   (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .lcd_if (bus_if.slave)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         passes = 0;
    int         next_line = 1;
    logic [4:0] exp_q [$];
    logic [7:0] model [32];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_nib(input logic rs, input logic [3:0] n);
        exp_q.push_back({rs, n});
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] b);
        push_nib(rs, b[7:4]);
        push_nib(rs, b[3:0]);
    endtask

    task automatic push_line(input int ln);
        push_byte(1'b0, (ln != 0) ? 8'hC0 : 8'h80);
        for (int i = 0; i < 16; i++) begin
            push_byte(1'b1, model[ln*16 + i]);
        end
    endtask

    task automatic push_init();
        for (int i = 0; i < 32; i++) model[i] = 8'h20;
        exp_q.delete();
        push_nib(1'b0, 4'h3);
        push_nib(1'b0, 4'h3);
        push_nib(1'b0, 4'h3);
        push_nib(1'b0, 4'h2);
        push_byte(1'b0, 8'h28);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h01);
        push_line(0);
        next_line = 1;
        passes = 0;
    endtask

    task automatic wait_passes(input int n, input string tag);
        int c = 0;
        while (passes < n && c < 3000) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk(tag, 32'(passes >= n), 32'd1);
    endtask

    task automatic wait_e_fall();
        int   c = 0;
        bit   seen = 1'b0;
        logic prev;
        prev = bus_if.control[2];
        while (!seen && c < 400) begin
            @(posedge clk);
            #1;
            if (prev && !bus_if.control[2]) seen = 1'b1;
            prev = bus_if.control[2];
            c++;
        end
        chk("e_fall_seen", 32'(seen), 32'd1);
    endtask

    task automatic check_pwrup_quiet(input string tag);
        int ehigh = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.control[2] !== 1'b0) ehigh++;
        end
        chk(tag, 32'(ehigh), 32'd0);
    endtask

    // Monitor: setup/hold, pulse width and scoreboard compare at each E pulse.
    initial begin
        logic       e_prev = 1'b0;
        logic [4:0] last = 5'h00;
        logic [4:0] cur;
        logic [4:0] exp;
        int         hi_cnt = 0;
        forever begin
            @(negedge clk);
            cur = {bus_if.control[1], bus_if.dataout};
            if (bus_if.control[2] === 1'b1 && e_prev === 1'b0) begin
                chk("setup", 32'(cur), 32'(last));
                chk("rw", 32'(bus_if.control[0]), 32'd0);
                hi_cnt = 1;
                if (exp_q.size() == 0) begin
                    chk("underflow", 32'd1, 32'd0);
                end else begin
                    exp = exp_q.pop_front();
                    chk("nibble", 32'(cur), 32'(exp));
                    if (exp_q.size() == 0) begin
                        push_line(next_line);
                        next_line = 1 - next_line;
                        passes++;
                    end
                end
            end else if (bus_if.control[2] === 1'b1) begin
                hi_cnt++;
            end else if (e_prev === 1'b1) begin
                chk("e_width", 32'(hi_cnt), 32'(E_CYC));
                chk("hold", 32'(cur), 32'(last));
            end
            e_prev = bus_if.control[2];
            last = cur;
        end
    end

    initial begin
        reset = 1'b1;
        bus_if.W = 1'b0;
        bus_if.WADD = 6'd0;
        bus_if.Din = 8'h00;
        push_init();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dataout", 32'(bus_if.dataout), 32'd0);
        chk("rst_control", 32'(bus_if.control), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        check_pwrup_quiet("pwrup_e_low");

        // Two full refresh passes of spaces, then write col 5 and an ignored address.
        wait_passes(3, "wait_pass3");
        bus_if.W = 1'b1;
        bus_if.WADD = 6'd5;
        bus_if.Din = 8'h37;
        model[5] = 8'h37;
        @(posedge clk);
        #1;
        bus_if.WADD = 6'd40;
        bus_if.Din = 8'h41;
        @(posedge clk);
        #1 bus_if.W = 1'b0;

        wait_passes(5, "wait_pass5");

        // Reset part-way through line 2 while a write to cell 0 is attempted.
        repeat (80) @(posedge clk);
        wait_e_fall();
        reset = 1'b1;
        bus_if.W = 1'b1;
        bus_if.WADD = 6'd0;
        bus_if.Din = 8'h39;
        push_init();
        @(negedge clk);
        chk("midrst_e", 32'(bus_if.control[2]), 32'd0);
        chk("midrst_dataout", 32'(bus_if.dataout), 32'd0);
        @(posedge clk);
        #1 bus_if.W = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        check_pwrup_quiet("restart_e_low");

        wait_passes(2, "wait_restart");
        chk("queue_live", 32'(exp_q.size() > 0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
